// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port synchronous RAM between the CPU and a loader/debug port.
// Define ARB_STATS_EN to add the conflict_cnt output counting cycles with a denied requester.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int HOLD_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  input  logic                  ldr_req,
  input  logic                  ldr_write,
  input  logic                  ldr_lock,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] hold_cnt;
  logic [3:0] hold_next;
  logic       rd_valid;
  logic       rd_owner;
  logic       rd_valid_next;

  // hold_cnt counts CPU wins while the loader waits; reaching HOLD_LIM hands the loader the next slot.
  always_comb begin
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      ARB: begin
        if (cpu_req && ldr_req) begin
          if (hold_cnt == HOLD_LIM) ldr_gnt = 1'b1;
          else                      cpu_gnt = 1'b1;
        end else begin
          cpu_gnt = cpu_req;
          ldr_gnt = ldr_req;
        end
        if (ldr_gnt || !ldr_req)    hold_next = 4'd0;
        else if (hold_cnt != HOLD_LIM) hold_next = hold_cnt + 4'd1;
        if (ldr_gnt && ldr_lock)    state_next = LOCK;
      end
      LOCK: begin
        ldr_gnt   = ldr_req;
        hold_next = 4'd0;
        if (!ldr_lock) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_write = cpu_gnt & cpu_write;
    if (ldr_gnt) begin
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_write = ldr_write;
    end
  end

  assign rd_valid_next = (cpu_gnt & ~cpu_write) | (ldr_gnt & ~ldr_write);

  // rd_owner remembers who issued last cycle's read so the shared rdata reaches the right side.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB;
      hold_cnt  <= 4'd0;
      rd_valid  <= 1'b0;
      rd_owner  <= 1'b0;
      cpu_stall <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      rd_valid  <= rd_valid_next;
      rd_owner  <= ldr_gnt;
      cpu_stall <= (state_next == LOCK);
    end
  end

  assign cpu_rvalid = rd_valid & ~rd_owner;
  assign ldr_rvalid = rd_valid & rd_owner;
  assign rdata      = ram_rdata;

`ifdef ARB_STATS_EN
  logic denied;

  assign denied = (cpu_req & ~cpu_gnt) | (ldr_req & ~ldr_gnt);

  always_ff @(posedge clk) begin
    if (!reset)                                  conflict_cnt <= 16'd0;
    else if (denied && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a rule-level arbitration model checked every cycle.
// Also exercises conflict_cnt when ARB_STATS_EN is defined.
module tb_mem_arbiter;

  localparam int HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        ldr_req = 1'b0, ldr_write = 1'b0, ldr_lock = 1'b0;
  logic [7:0]  ldr_addr = 8'h00;
  logic [15:0] ldr_wdata = 16'h0000;
  logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, cpu_stall, ram_write;
  logic [15:0] rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;
`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int total = 0;
  int bad = 0;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .ldr_req(ldr_req), .ldr_write(ldr_write), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .rdata(rdata), .cpu_stall(cpu_stall),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench-side RAM: 1-cycle synchronous read, contents RAM[i] = 0x1000+i except RAM[5] = 0x1234.
  initial begin
    logic [15:0] ram [256];
    for (int i = 0; i < 256; i++) ram[i] = 16'(4096 + i);
    ram[5] = 16'h1234;
    forever begin
      @(posedge clk);
      if (ram_write) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic cr, input logic cw,
                               input logic [7:0] ca, input logic [15:0] cd,
                               input logic lr, input logic lw, input logic ll,
                               input logic [7:0] la, input logic [15:0] ld);
    @(posedge clk);
    #1;
    reset = rst;
    cpu_req = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_write = lw; ldr_lock = ll; ldr_addr = la; ldr_wdata = ld;
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  // Model: who should own the bus this cycle, derived from lock/starvation rules,
  // plus a private copy of memory contents to predict returned read data.
  initial begin
    logic [15:0] model_mem [256];
    bit          started = 0;
    bit          m_locked = 0, m_cpu_rv = 0, m_ldr_rv = 0;
    int          m_waits = 0;
    int          m_conf = 0;
    logic [15:0] m_rdata = 16'h0000;
    bit          eg_c, eg_l;
    logic [7:0]  a;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'(4096 + i);
    model_mem[5] = 16'h1234;
    forever begin
      @(negedge clk);
      if (m_locked)                 begin eg_c = 0;       eg_l = ldr_req; end
      else if (cpu_req && ldr_req)  begin eg_l = (m_waits >= HOLD_MAX); eg_c = !eg_l; end
      else                          begin eg_c = cpu_req; eg_l = ldr_req; end
      a = eg_l ? ldr_addr : cpu_addr;
      if (started) begin
        checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
        checkOutput("ldr_rvalid", 32'(ldr_rvalid), 32'(m_ldr_rv));
        checkOutput("cpu_stall", 32'(cpu_stall), 32'(m_locked));
        if (m_cpu_rv || m_ldr_rv) checkOutput("rdata", 32'(rdata), 32'(m_rdata));
`ifdef ARB_STATS_EN
        checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
        if (reset) begin
          checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
          checkOutput("ldr_gnt", 32'(ldr_gnt), 32'(eg_l));
          checkOutput("ram_write", 32'(ram_write), 32'((eg_c && cpu_write) || (eg_l && ldr_write)));
          checkOutput("ram_addr", 32'(ram_addr), 32'(a));
          checkOutput("ram_wdata", 32'(ram_wdata), 32'(eg_l ? ldr_wdata : cpu_wdata));
        end
      end
      if (!reset) begin
        started = 1; m_locked = 0; m_waits = 0; m_cpu_rv = 0; m_ldr_rv = 0; m_conf = 0;
      end else begin
        m_cpu_rv = eg_c && !cpu_write;
        m_ldr_rv = eg_l && !ldr_write;
        if (eg_c || eg_l) begin
          m_rdata = model_mem[a];
          if ((eg_c && cpu_write) || (eg_l && ldr_write)) model_mem[a] = eg_l ? ldr_wdata : cpu_wdata;
        end
        if (((cpu_req && !eg_c) || (ldr_req && !eg_l)) && m_conf < 65535) m_conf++;
        if (m_locked || eg_l || !ldr_req) m_waits = 0;
        else if (m_waits < HOLD_MAX)      m_waits++;
        m_locked = m_locked ? ldr_lock : (eg_l && ldr_lock);
      end
    end
  end

  initial begin
    repeat (3) idle(1'b0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("reset_stall", 32'(cpu_stall), 32'd0);
    checkOutput("reset_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 32'd0);

    // CPU read of address 5
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    checkOutput("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    idle(1'b1);
    @(negedge clk);
    checkOutput("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("t1_rdata", 32'(rdata), 32'h1234);
    checkOutput("t1_ldr_rvalid", 32'(ldr_rvalid), 32'd0);

    // Contention: four CPU grants then one loader grant, repeating
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(i), 16'h0, 1'b1, 1'b0, 1'b0, 8'(32 + i), 16'h0);
      @(negedge clk);
      checkOutput("t2_ldr_gnt", 32'(ldr_gnt), 32'((i % 5) == 4));
      checkOutput("t2_cpu_gnt", 32'(cpu_gnt), 32'((i % 5) != 4));
    end
    idle(1'b1);

    // Loader lock burst writing 0xA5A0..0xA5A3 to 0x10..0x13
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h12, 16'h0, 1'b1, 1'b1, 1'b1, 8'h10, 16'hA5A0);
    @(negedge clk);
    checkOutput("t3_enter_gnt", 32'(ldr_gnt), 32'd1);
    checkOutput("t3_enter_stall", 32'(cpu_stall), 32'd0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h12, 16'h0, 1'b1, 1'b1, 1'b1, 8'(16 + k), 16'(16'hA5A0 + k));
      @(negedge clk);
      checkOutput("t3_cpu_gnt", 32'(cpu_gnt), 32'd0);
      checkOutput("t3_stall", 32'(cpu_stall), 32'd1);
      checkOutput("t3_ldr_gnt", 32'(ldr_gnt), 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h12, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    checkOutput("t3_exit_cpu_gnt", 32'(cpu_gnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h12, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    checkOutput("t3_arb_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("t3_arb_stall", 32'(cpu_stall), 32'd0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("t3_read_back", 32'(rdata), 32'hA5A2);
    checkOutput("t3_read_valid", 32'(cpu_rvalid), 32'd1);

    // Alternating reads: CPU 0x01 then loader 0x02
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0);
    @(negedge clk);
    checkOutput("t4_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("t4_cpu_rdata", 32'(rdata), 32'h1001);
    checkOutput("t4_no_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("t4_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
    checkOutput("t4_ldr_rdata", 32'(rdata), 32'h1002);
    checkOutput("t4_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // Reset while locked with a read in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 1'b1, 8'h30, 16'hBEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 16'h0, 1'b1, 1'b0, 1'b1, 8'h02, 16'h0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("t5_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    checkOutput("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("t5_stall", 32'(cpu_stall), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 16'h0, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0);
      @(negedge clk);
      checkOutput("t5_hold_pattern", 32'(ldr_gnt), 32'(i == 4));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("t5_cpu_drop", 32'(cpu_rvalid), 32'd0);

`ifdef ARB_STATS_EN
    idle(1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("t6_conflict_cnt", 32'(conflict_cnt), 32'd10);
`endif

    repeat (2) idle(1'b1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
